// File: rtl/tts_pkg.sv
// rtl/tts_pkg.sv - shared types and constants for the truth table scanner
package tts_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int N_IN   = 4;
   localparam int N_ROWS = 16;

   // Truth table of F = AC' + B'D + A'CD + ABCD, bit i = F(abcd == i)
   localparam logic [N_ROWS-1:0] F_GOLDEN = 16'hBB8A;
endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - counts DWELL cycles per step; tick marks the last cycle
module dwell_timer #(
   parameter int DWELL = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);
   localparam int W = $clog2(DWELL + 1);

   logic [W-1:0] r_cnt;
   logic         w_last;

   assign w_last = (r_cnt == W'(DWELL - 1));
   assign tick   = w_last;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= w_last ? '0 : r_cnt + W'(1);
      end
   end
endmodule

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - clocked scan of a 4-input function with capture and compare
module truth_table_scanner
   import tts_pkg::*;
#(
   parameter int                DWELL    = 2,
   parameter logic [N_ROWS-1:0] EXPECTED = F_GOLDEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              f_in,
   output logic [N_IN-1:0]   abcd,
   output logic              busy,
   output logic              done,
   output logic [N_ROWS-1:0] table_q,
   output logic              match,
   output logic [4:0]        err_cnt
);
   state_t              r_state;
   logic [N_IN-1:0]     r_idx;
   logic [N_ROWS-1:0]   r_table;
   logic [4:0]          r_err;
   logic                w_in_drive;
   logic                w_tick;
   logic                w_sample;

   assign w_in_drive = (r_state == DRIVE);
   assign w_sample   = w_in_drive && w_tick;

   // Timer is held clear outside DRIVE so every scan starts at count 0
   dwell_timer #(
      .DWELL (DWELL)
   ) u_dwell (
      .clk  (clk),
      .rst  (rst),
      .clr  (!w_in_drive),
      .en   (w_in_drive),
      .tick (w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_table <= '0;
         r_err   <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_state <= DRIVE;
                  r_idx   <= '0;
                  r_table <= '0;
                  r_err   <= '0;
               end
            end
            DRIVE: begin
               if (w_sample) begin
                  r_table[r_idx] <= f_in;
                  if (f_in != EXPECTED[r_idx]) begin
                     r_err <= r_err + 5'd1;
                  end
                  if (r_idx == N_IN'(N_ROWS - 1)) begin
                     r_state <= DONE;
                  end else begin
                     r_idx <= r_idx + N_IN'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign abcd    = r_idx;
   assign busy    = w_in_drive;
   assign done    = (r_state == DONE);
   assign table_q = r_table;
   assign err_cnt = r_err;
   assign match   = done && (r_table == EXPECTED);
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - randomized self-checking bench for truth_table_scanner
module tb_truth_table_scanner;
   logic        clk = 1'b0;
   logic        rst;
   logic        start   [2];
   logic        f_in    [2];
   logic [3:0]  abcd    [2];
   logic        busy    [2];
   logic        done    [2];
   logic        match   [2];
   logic [15:0] table_q [2];
   logic [4:0]  err_cnt [2];
   logic [15:0] fn_tbl  [2];
   logic [15:0] golden;
   int          dw [2] = '{2, 1};
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   assign f_in[0] = fn_tbl[0][abcd[0]];
   assign f_in[1] = fn_tbl[1][abcd[1]];

   truth_table_scanner #(.DWELL(2)) dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .f_in(f_in[0]), .abcd(abcd[0]),
      .busy(busy[0]), .done(done[0]), .table_q(table_q[0]), .match(match[0]),
      .err_cnt(err_cnt[0])
   );

   truth_table_scanner #(.DWELL(1)) dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .f_in(f_in[1]), .abcd(abcd[1]),
      .busy(busy[1]), .done(done[1]), .table_q(table_q[1]), .match(match[1]),
      .err_cnt(err_cnt[1])
   );

   function automatic logic f_expr(input int i);
      logic a, b, c, d;
      a = i[3]; b = i[2]; c = i[1]; d = i[0];
      return (a & ~c) | (~b & d) | (~a & c & d) | (a & b & c & d);
   endfunction

   task automatic check_idle(input int s, input string nm);
      checks++;
      if (abcd[s] !== 4'd0 || busy[s] !== 1'b0 || done[s] !== 1'b0 ||
          table_q[s] !== 16'd0 || err_cnt[s] !== 5'd0 || match[s] !== 1'b0) begin
         errors++;
         $display("FAIL %s inst%0d: abcd=%h busy=%b done=%b table=%h err=%0d match=%b, want all zero",
                  nm, s, abcd[s], busy[s], done[s], table_q[s], err_cnt[s], match[s]);
      end
   endtask

   task automatic scan(input int s, input logic [15:0] fn, input bit repulse, input string nm);
      int         d;
      int         exp_err;
      d = dw[s];
      fn_tbl[s] = fn;
      @(negedge clk); start[s] = 1'b1;
      @(negedge clk); start[s] = 1'b0;
      for (int k = 0; k <= 16 * d; k++) begin
         if (k == 0) begin
            checks++;
            if (table_q[s] !== 16'd0 || err_cnt[s] !== 5'd0 || done[s] !== 1'b0) begin
               errors++;
               $display("FAIL %s inst%0d start_clear: table=%h err=%0d done=%b, want 0/0/0",
                        nm, s, table_q[s], err_cnt[s], done[s]);
            end
         end
         if (k < 16 * d) begin
            checks++;
            if (abcd[s] !== 4'(k / d) || busy[s] !== 1'b1 || done[s] !== 1'b0) begin
               errors++;
               $display("FAIL %s inst%0d step k=%0d: abcd=%0d busy=%b done=%b, want abcd=%0d busy=1 done=0",
                        nm, s, k, abcd[s], busy[s], done[s], k / d);
            end
            start[s] = (repulse && (k == 3 * d || k == 10 * d)) ? 1'b1 : 1'b0;
            @(negedge clk);
         end else begin
            checks++;
            if (done[s] !== 1'b1 || busy[s] !== 1'b0 || abcd[s] !== 4'hF) begin
               errors++;
               $display("FAIL %s inst%0d done_time: done=%b busy=%b abcd=%h, want done=1 busy=0 abcd=f",
                        nm, s, done[s], busy[s], abcd[s]);
            end
         end
      end
      start[s] = 1'b0;
      exp_err = 0;
      for (int i = 0; i < 16; i++) if (fn[i] != golden[i]) exp_err++;
      checks++;
      if (table_q[s] !== fn) begin
         errors++;
         $display("FAIL %s inst%0d table: got %h want %h", nm, s, table_q[s], fn);
      end
      checks++;
      if (err_cnt[s] !== 5'(exp_err)) begin
         errors++;
         $display("FAIL %s inst%0d err_cnt: got %0d want %0d", nm, s, err_cnt[s], exp_err);
      end
      checks++;
      if (match[s] !== (fn == golden)) begin
         errors++;
         $display("FAIL %s inst%0d match: got %b want %b", nm, s, match[s], fn == golden);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_idle(0, "reset");
      check_idle(1, "reset");
      rst = 1'b0;
   endtask

   task automatic test_mid_reset();
      fn_tbl[0] = golden;
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      for (int c = 0; c < 100 && abcd[0] !== 4'd6; c++) @(negedge clk);
      checks++;
      if (abcd[0] !== 4'd6) begin
         errors++;
         $display("FAIL mid_reset wait: abcd=%0d never reached 6", abcd[0]);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle(0, "mid_reset");
      scan(0, golden, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      repeat (4) begin
         for (int s = 0; s < 2; s++) begin
            scan(s, 16'($urandom), 1'($urandom_range(0, 1)), "random");
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) golden[i] = f_expr(i);
      start[0] = 1'b0; start[1] = 1'b0;
      fn_tbl[0] = 16'd0; fn_tbl[1] = 16'd0;
      rst = 1'b1;
      test_reset();
      scan(0, golden, 1'b0, "correct");
      scan(0, 16'h0000, 1'b0, "stuck0");
      scan(0, 16'hFFFF, 1'b0, "stuck1");
      test_mid_reset();
      scan(0, golden, 1'b1, "repulse");
      scan(0, 16'h0000, 1'b0, "from_done");
      scan(1, golden, 1'b0, "dwell1");
      scan(1, golden, 1'b1, "dwell1_repulse");
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
